// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared widths and FIFO entry type for the MIPS fetch stage
package mips_fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;
   localparam logic [PC_W-1:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
      return {a[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mips_fetch_if.sv
// rtl/mips_fetch_if.sv - fetch stage bus: instruction memory port, core handshake, redirect
interface mips_fetch_if;
   import mips_fetch_pkg::*;

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    instr_pc;
   logic [PC_W-1:0]    instr_pcplus4;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4,
      input  imem_rdata, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4,
      output imem_rdata, instr_ready, redirect, redirect_pc
   );

endinterface

// File: rtl/mips_fetch_fifo.sv
// rtl/mips_fetch_fifo.sv - synchronous FIFO of {pc, instr} entries with flush
module fetch_fifo
   import mips_fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_flush,
   input  logic         i_push,
   input  fetch_entry_t i_push_data,
   input  logic         i_pop,
   output fetch_entry_t o_head,
   output logic [CW-1:0] o_count,
   output logic         o_full,
   output logic         o_empty
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // Guarded so a misbehaving producer cannot corrupt live entries.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !i_flush && w_push)
         r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(i_push && !i_flush && o_full));

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - sequential instruction fetch with credit-based issue and redirect flush
module mips_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter  int              DEPTH    = 4,
   parameter  logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   localparam int              CW       = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         reset,
   mips_fetch_if.master bus
);

   logic [PC_W-1:0] r_fpc;
   logic [PC_W-1:0] r_inflight_pc;
   logic            r_inflight;

   logic [CW-1:0]   w_count;
   logic [CW:0]     w_credit;
   logic            w_full;
   logic            w_empty;
   logic            w_issue;
   logic            w_push;
   logic            w_pop;
   fetch_entry_t    w_push_data;
   fetch_entry_t    w_head;

   // Credits count the in-flight word as occupied; a same-cycle pop is deliberately not credited.
   assign w_credit    = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue     = !reset && !bus.redirect && (w_credit < (CW+1)'(DEPTH));
   assign w_push      = r_inflight;
   assign w_pop       = bus.instr_valid && bus.instr_ready;
   assign w_push_data = '{pc: r_inflight_pc, instr: bus.imem_rdata};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (bus.redirect),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fpc         <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= RESET_PC;
      end else if (bus.redirect) begin
         r_fpc      <= word_align(bus.redirect_pc);
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_fpc         <= r_fpc + PC_INC;
            r_inflight_pc <= r_fpc;
         end
      end
   end

   assign bus.imem_req      = w_issue;
   assign bus.imem_addr     = r_fpc;
   assign bus.instr_valid   = !w_empty && !reset;
   assign bus.instr         = w_head.instr;
   assign bus.instr_pc      = w_head.pc;
   assign bus.instr_pcplus4 = w_head.pc + PC_INC;

   a_push_has_room: assert property (@(posedge clk) disable iff (reset)
      (w_push && !bus.redirect) |-> !w_full);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - bench for mips_fetch_unit: directed literals plus random stream vs queue model
module tb_mips_fetch_unit;
   import mips_fetch_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC_A = 32'h0000_0000;
   localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   mips_fetch_if bus_a();
   mips_fetch_if bus_b();

   mips_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   mips_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   always #5 clk = ~clk;

   assign bus_b.instr_ready = 1'b1;
   assign bus_b.redirect    = 1'b0;
   assign bus_b.redirect_pc = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction memory: registered, answers one cycle after each request.
   logic        a_preq, b_preq;
   logic [31:0] a_paddr, b_paddr;
   always @(negedge clk) begin
      a_preq  = bus_a.imem_req;
      a_paddr = bus_a.imem_addr;
      b_preq  = bus_b.imem_req;
      b_paddr = bus_b.imem_addr;
   end
   always begin
      @(posedge clk);
      #1;
      bus_a.imem_rdata = a_preq ? mem_word(a_paddr) : $urandom;
      bus_b.imem_rdata = b_preq ? mem_word(b_paddr) : $urandom;
   end

   // Reference model: buffered PCs as a queue, plus the next PC the core must see.
   logic [31:0] mq[$];
   bit          m_inf;
   logic [31:0] m_inf_pc;
   logic [31:0] m_fpc;
   logic [31:0] m_next;

   always @(negedge clk) begin
      bit m_req;
      if (reset) begin
         chk("rst_req", 32'(bus_a.imem_req), 32'd0);
         chk("rst_valid", 32'(bus_a.instr_valid), 32'd0);
         mq.delete();
         m_inf  = 1'b0;
         m_fpc  = RPC_A;
         m_next = RPC_A;
      end else begin
         m_req = !bus_a.redirect && (mq.size() + int'(m_inf) < DEPTH);
         chk("req", 32'(bus_a.imem_req), 32'(m_req));
         if (m_req) chk("addr", bus_a.imem_addr, m_fpc);
         chk("valid", 32'(bus_a.instr_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("pc_seq", bus_a.instr_pc, m_next);
            chk("pc", bus_a.instr_pc, mq[0]);
            chk("instr", bus_a.instr, mem_word(mq[0]));
            chk("pcplus4", bus_a.instr_pcplus4, mq[0] + 32'd4);
         end
         if (bus_a.redirect) begin
            mq.delete();
            m_inf  = 1'b0;
            m_fpc  = {bus_a.redirect_pc[31:2], 2'b00};
            m_next = m_fpc;
         end else begin
            if (mq.size() != 0 && bus_a.instr_ready) begin
               void'(mq.pop_front());
               m_next = m_next + 32'd4;
            end
            if (m_inf) mq.push_back(m_inf_pc);
            m_inf = m_req;
            if (m_req) begin
               m_inf_pc = m_fpc;
               m_fpc    = m_fpc + 32'd4;
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      int mode;
      bus_a.instr_ready = 1'b1;
      bus_a.redirect    = 1'b0;
      bus_a.redirect_pc = 32'h0;

      // Streaming after reset, plus the wrap-around instance.
      repeat (3) next_cycle();
      reset = 1'b0;
      sample();
      chk("A_c0_req", 32'(bus_a.imem_req), 32'd1);
      chk("A_c0_addr", bus_a.imem_addr, 32'h0);
      chk("B_c0_addr", bus_b.imem_addr, 32'hFFFF_FFF8);
      next_cycle(); sample();
      chk("A_c1_valid", 32'(bus_a.instr_valid), 32'd0);
      next_cycle(); sample();
      chk("A_c2_valid", 32'(bus_a.instr_valid), 32'd1);
      chk("A_c2_pc", bus_a.instr_pc, 32'h0);
      chk("A_c2_instr", bus_a.instr, 32'h0000_FFFF);
      chk("B_c2_valid", 32'(bus_b.instr_valid), 32'd1);
      chk("B_c2_pc", bus_b.instr_pc, 32'hFFFF_FFF8);
      next_cycle(); sample();
      chk("A_c3_pc", bus_a.instr_pc, 32'h4);
      chk("B_c3_pc", bus_b.instr_pc, 32'hFFFF_FFFC);
      chk("B_c3_instr", bus_b.instr, 32'hFFFC_0000);
      chk("B_c3_pcplus4", bus_b.instr_pcplus4, 32'h0);
      next_cycle(); sample();
      chk("A_c4_pc", bus_a.instr_pc, 32'h8);
      chk("A_c4_pcplus4", bus_a.instr_pcplus4, 32'hC);
      chk("B_c4_pc", bus_b.instr_pc, 32'h0);
      chk("B_c4_instr", bus_b.instr, 32'h0000_FFFF);

      // Back-pressure: fill to DEPTH, stall requests, then drain in order.
      next_cycle();
      bus_a.instr_ready = 1'b0;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         sample();
         if (k == 3) chk("B_c3_addr", bus_a.imem_addr, 32'hC);
         if (k == 4 || k == 9) chk("B_stall_req", 32'(bus_a.imem_req), 32'd0);
         next_cycle();
      end
      bus_a.instr_ready = 1'b1;
      sample();
      chk("B_c10_pc", bus_a.instr_pc, 32'h0);
      chk("B_c10_req", 32'(bus_a.imem_req), 32'd0);
      next_cycle(); sample();
      chk("B_c11_pc", bus_a.instr_pc, 32'h4);
      chk("B_c11_addr", bus_a.imem_addr, 32'h10);
      next_cycle(); sample();
      chk("B_c12_pc", bus_a.instr_pc, 32'h8);
      next_cycle(); sample();
      chk("B_c13_pc", bus_a.instr_pc, 32'hC);
      next_cycle(); sample();
      chk("B_c14_pc", bus_a.instr_pc, 32'h10);

      // Redirect with three buffered entries and one in flight.
      next_cycle();
      bus_a.instr_ready = 1'b0;
      do_reset();
      repeat (4) begin sample(); next_cycle(); end
      bus_a.redirect    = 1'b1;
      bus_a.redirect_pc = 32'h0000_0103;
      sample();
      chk("C_c4_req", 32'(bus_a.imem_req), 32'd0);
      next_cycle();
      bus_a.redirect    = 1'b0;
      bus_a.instr_ready = 1'b1;
      sample();
      chk("C_c5_addr", bus_a.imem_addr, 32'h100);
      chk("C_c5_valid", 32'(bus_a.instr_valid), 32'd0);
      next_cycle(); sample();
      chk("C_c6_valid", 32'(bus_a.instr_valid), 32'd0);
      next_cycle(); sample();
      chk("C_c7_pc", bus_a.instr_pc, 32'h100);
      chk("C_c7_instr", bus_a.instr, 32'h0100_FFFF);
      next_cycle(); sample();
      chk("C_c8_pc", bus_a.instr_pc, 32'h104);

      // Reset in mid-stream with the FIFO half full.
      next_cycle();
      bus_a.instr_ready = 1'b0;
      do_reset();
      repeat (3) begin sample(); next_cycle(); end
      reset = 1'b1;
      sample();
      chk("D_rst_valid", 32'(bus_a.instr_valid), 32'd0);
      chk("D_rst_req", 32'(bus_a.imem_req), 32'd0);
      next_cycle();
      reset = 1'b0;
      bus_a.instr_ready = 1'b1;
      sample();
      chk("D_c0_valid", 32'(bus_a.instr_valid), 32'd0);
      next_cycle(); sample();
      chk("D_c1_valid", 32'(bus_a.instr_valid), 32'd0);
      next_cycle(); sample();
      chk("D_c2_pc", bus_a.instr_pc, RPC_A);

      // Random ready, redirects and occasional reset.
      mode = 0;
      for (int n = 0; n < 4000; n++) begin
         next_cycle();
         if (n % 50 == 0) mode = $urandom_range(0, 2);
         reset = ($urandom_range(0, 299) == 0);
         case (mode)
            0:       bus_a.instr_ready = ($urandom_range(0, 9) == 0);
            1:       bus_a.instr_ready = ($urandom_range(0, 9) < 7);
            default: bus_a.instr_ready = 1'b1;
         endcase
         bus_a.redirect    = ($urandom_range(0, 24) == 0);
         bus_a.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
      end
      next_cycle();
      reset = 1'b1;
      bus_a.redirect = 1'b0;
      sample();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
